// File: rtl/gru_stream_weight_loader.sv
// Streams GRU/FC weight words into a shadow bank and commits them to the output buses in one edge.
// Define GRU_WEIGHT_CHECKSUM_EN to require a trailing sum-of-words checksum before commit.
module gru_stream_weight_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int INPUT_FEATURES = 3,
  parameter int GRU_UNITS      = 3
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            i_load_start,
  input  logic                                            i_abort,
  input  logic [DATA_WIDTH-1:0]                           i_wdata,
  input  logic                                            i_wvalid,
  output logic                                            o_wready,
  output logic                                            o_busy,
  output logic                                            o_load_done,
  output logic                                            o_weights_valid,
  output logic                                            o_checksum_err,
  output logic [GRU_UNITS*INPUT_FEATURES*DATA_WIDTH-1:0]  o_Wr_flat,
  output logic [GRU_UNITS*INPUT_FEATURES*DATA_WIDTH-1:0]  o_Wz_flat,
  output logic [GRU_UNITS*INPUT_FEATURES*DATA_WIDTH-1:0]  o_Wh_flat,
  output logic [GRU_UNITS*GRU_UNITS*DATA_WIDTH-1:0]       o_Ur_flat,
  output logic [GRU_UNITS*GRU_UNITS*DATA_WIDTH-1:0]       o_Uz_flat,
  output logic [GRU_UNITS*GRU_UNITS*DATA_WIDTH-1:0]       o_Uh_flat,
  output logic [GRU_UNITS*DATA_WIDTH-1:0]                 o_br_flat,
  output logic [GRU_UNITS*DATA_WIDTH-1:0]                 o_bz_flat,
  output logic [GRU_UNITS*DATA_WIDTH-1:0]                 o_bh_flat,
  output logic [GRU_UNITS*DATA_WIDTH-1:0]                 o_fc_weights_flat,
  output logic [DATA_WIDTH-1:0]                           o_fc_bias
);

  localparam int UF = GRU_UNITS * INPUT_FEATURES;
  localparam int UU = GRU_UNITS * GRU_UNITS;
  localparam int U  = GRU_UNITS;
  localparam int CW = $clog2(UF + UU + U + 1);
  localparam logic [3:0] LAST_SEG = 4'd10;

  // state  | meaning
  // IDLE   | waiting for i_load_start
  // LOAD   | accepting weight words into the shadow bank
  // CHECK  | accepting the checksum word (checksum build only)
  // COMMIT | copying the shadow bank to the outputs
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

  state_t          state;
  logic [3:0]      seg_idx;
  logic [CW-1:0]   word_cnt;
  logic            wready_q;
  logic            transfer;
  logic            last_in_seg;
  logic            last_word;

  logic [UF*DATA_WIDTH-1:0] sh_wr, sh_wz, sh_wh;
  logic [UU*DATA_WIDTH-1:0] sh_ur, sh_uz, sh_uh;
  logic [U*DATA_WIDTH-1:0]  sh_br, sh_bz, sh_bh, sh_fcw;
  logic [DATA_WIDTH-1:0]    sh_fcb;

`ifdef GRU_WEIGHT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]    csum;
  logic                     checksum_err;
  assign o_checksum_err = checksum_err;
`else
  assign o_checksum_err = 1'b0;
`endif

  function automatic logic [CW-1:0] seg_last(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: seg_last = CW'(UF - 1);
      4'd1, 4'd4, 4'd7: seg_last = CW'(UU - 1);
      4'd10:            seg_last = '0;
      default:          seg_last = CW'(U - 1);
    endcase
  endfunction

  // Abort wins over a simultaneous word, so it also masks ready.
  assign o_wready    = wready_q && !i_abort;
  assign transfer    = i_wvalid && o_wready;
  assign last_in_seg = (word_cnt == seg_last(seg_idx));
  assign last_word   = last_in_seg && (seg_idx == LAST_SEG);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      seg_idx           <= '0;
      word_cnt          <= '0;
      wready_q          <= 1'b0;
      o_busy            <= 1'b0;
      o_load_done       <= 1'b0;
      o_weights_valid   <= 1'b0;
      sh_wr             <= '0;
      sh_wz             <= '0;
      sh_wh             <= '0;
      sh_ur             <= '0;
      sh_uz             <= '0;
      sh_uh             <= '0;
      sh_br             <= '0;
      sh_bz             <= '0;
      sh_bh             <= '0;
      sh_fcw            <= '0;
      sh_fcb            <= '0;
      o_Wr_flat         <= '0;
      o_Wz_flat         <= '0;
      o_Wh_flat         <= '0;
      o_Ur_flat         <= '0;
      o_Uz_flat         <= '0;
      o_Uh_flat         <= '0;
      o_br_flat         <= '0;
      o_bz_flat         <= '0;
      o_bh_flat         <= '0;
      o_fc_weights_flat <= '0;
      o_fc_bias         <= '0;
`ifdef GRU_WEIGHT_CHECKSUM_EN
      csum              <= '0;
      checksum_err      <= 1'b0;
`endif
    end else begin
      o_load_done <= 1'b0;
      case (state)
        IDLE: begin
          o_busy <= 1'b0;
          if (i_load_start) begin
            state    <= LOAD;
            seg_idx  <= '0;
            word_cnt <= '0;
            wready_q <= 1'b1;
            o_busy   <= 1'b1;
`ifdef GRU_WEIGHT_CHECKSUM_EN
            csum         <= '0;
            checksum_err <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (i_abort) begin
            state    <= IDLE;
            wready_q <= 1'b0;
            o_busy   <= 1'b0;
          end else if (transfer) begin
            // Words arrive in order, so shifting in at the top leaves word k at slot k.
            case (seg_idx)
              4'd0:    sh_wr  <= {i_wdata, sh_wr[UF*DATA_WIDTH-1:DATA_WIDTH]};
              4'd1:    sh_ur  <= {i_wdata, sh_ur[UU*DATA_WIDTH-1:DATA_WIDTH]};
              4'd2:    sh_br  <= {i_wdata, sh_br[U*DATA_WIDTH-1:DATA_WIDTH]};
              4'd3:    sh_wz  <= {i_wdata, sh_wz[UF*DATA_WIDTH-1:DATA_WIDTH]};
              4'd4:    sh_uz  <= {i_wdata, sh_uz[UU*DATA_WIDTH-1:DATA_WIDTH]};
              4'd5:    sh_bz  <= {i_wdata, sh_bz[U*DATA_WIDTH-1:DATA_WIDTH]};
              4'd6:    sh_wh  <= {i_wdata, sh_wh[UF*DATA_WIDTH-1:DATA_WIDTH]};
              4'd7:    sh_uh  <= {i_wdata, sh_uh[UU*DATA_WIDTH-1:DATA_WIDTH]};
              4'd8:    sh_bh  <= {i_wdata, sh_bh[U*DATA_WIDTH-1:DATA_WIDTH]};
              4'd9:    sh_fcw <= {i_wdata, sh_fcw[U*DATA_WIDTH-1:DATA_WIDTH]};
              4'd10:   sh_fcb <= i_wdata;
              default: ;
            endcase
`ifdef GRU_WEIGHT_CHECKSUM_EN
            csum <= csum + i_wdata;
`endif
            if (last_in_seg) begin
              word_cnt <= '0;
              seg_idx  <= seg_idx + 4'd1;
            end else begin
              word_cnt <= word_cnt + CW'(1);
            end
            if (last_word) begin
`ifdef GRU_WEIGHT_CHECKSUM_EN
              state    <= CHECK;
`else
              state    <= COMMIT;
              wready_q <= 1'b0;
`endif
            end
          end
        end
`ifdef GRU_WEIGHT_CHECKSUM_EN
        CHECK: begin
          if (i_abort) begin
            state    <= IDLE;
            wready_q <= 1'b0;
            o_busy   <= 1'b0;
          end else if (transfer) begin
            wready_q <= 1'b0;
            if (i_wdata == csum) begin
              state <= COMMIT;
            end else begin
              state        <= IDLE;
              checksum_err <= 1'b1;
              o_busy       <= 1'b0;
            end
          end
        end
`endif
        COMMIT: begin
          o_Wr_flat         <= sh_wr;
          o_Ur_flat         <= sh_ur;
          o_br_flat         <= sh_br;
          o_Wz_flat         <= sh_wz;
          o_Uz_flat         <= sh_uz;
          o_bz_flat         <= sh_bz;
          o_Wh_flat         <= sh_wh;
          o_Uh_flat         <= sh_uh;
          o_bh_flat         <= sh_bh;
          o_fc_weights_flat <= sh_fcw;
          o_fc_bias         <= sh_fcb;
          o_weights_valid   <= 1'b1;
          o_load_done       <= 1'b1;
          o_busy            <= 1'b1;
          state             <= IDLE;
        end
        default: begin
          state    <= IDLE;
          wready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gru_stream_weight_loader.sv
// Randomized bench for gru_stream_weight_loader: a word-list model predicts every output each cycle.
module tb_gru_stream_weight_loader;
  localparam int DW = 32;
  localparam int F  = 3;
  localparam int U  = 3;
  localparam int UF = U * F;
  localparam int UU = U * U;
  localparam int L  = UF + UU + U;
  localparam int N  = 3 * L + U + 1;
  localparam int SW = ((UF > UU) ? UF : UU) * DW;
`ifdef GRU_WEIGHT_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic rst, i_load_start, i_abort, i_wvalid;
  logic [DW-1:0] i_wdata;
  logic o_wready, o_busy, o_load_done, o_weights_valid, o_checksum_err;
  logic [UF*DW-1:0] o_Wr_flat, o_Wz_flat, o_Wh_flat;
  logic [UU*DW-1:0] o_Ur_flat, o_Uz_flat, o_Uh_flat;
  logic [U*DW-1:0]  o_br_flat, o_bz_flat, o_bh_flat, o_fc_weights_flat;
  logic [DW-1:0]    o_fc_bias;

  always #5 clk = ~clk;

  gru_stream_weight_loader #(.DATA_WIDTH(DW), .INPUT_FEATURES(F), .GRU_UNITS(U)) dut (
    .clk(clk), .rst(rst), .i_load_start(i_load_start), .i_abort(i_abort),
    .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready), .o_busy(o_busy),
    .o_load_done(o_load_done), .o_weights_valid(o_weights_valid), .o_checksum_err(o_checksum_err),
    .o_Wr_flat(o_Wr_flat), .o_Wz_flat(o_Wz_flat), .o_Wh_flat(o_Wh_flat),
    .o_Ur_flat(o_Ur_flat), .o_Uz_flat(o_Uz_flat), .o_Uh_flat(o_Uh_flat),
    .o_br_flat(o_br_flat), .o_bz_flat(o_bz_flat), .o_bh_flat(o_bh_flat),
    .o_fc_weights_flat(o_fc_weights_flat), .o_fc_bias(o_fc_bias)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int s_cyc = 0;
  int done_cnt = 0;
  bit chk_en = 0;
  logic [DW-1:0] tx_sum;

  // Model: the stream is a list of N words; a load is a count of accepted words.
  logic [DW-1:0] m_words [N];
  logic [DW-1:0] m_out [N];
  int m_cnt = 0;
  bit m_active = 0, m_pending = 0, m_done = 0, m_wv = 0, m_err = 0;

  function automatic logic [DW-1:0] word_sum();
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + m_words[k];
    return s;
  endfunction

  function automatic logic [SW-1:0] seg(input int first, input int len);
    logic [SW-1:0] r;
    r = '0;
    for (int k = len - 1; k >= 0; k--) r = (r << DW) | SW'(m_out[first + k]);
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      chk_en = 1;
      m_active = 0; m_pending = 0; m_done = 0; m_wv = 0; m_err = 0; m_cnt = 0;
      for (int k = 0; k < N; k++) begin m_out[k] = '0; m_words[k] = '0; end
    end else begin
      m_done = 0;
      if (m_pending) begin
        m_out = m_words; m_wv = 1; m_done = 1; m_pending = 0;
      end else if (!m_active) begin
        if (i_load_start) begin m_active = 1; m_cnt = 0; m_err = 0; end
      end else if (i_abort) begin
        m_active = 0;
      end else if (i_wvalid) begin
        if (m_cnt < N) begin
          m_words[m_cnt] = i_wdata;
          m_cnt++;
          if (m_cnt == N && CK == 0) begin m_active = 0; m_pending = 1; end
        end else begin
          m_active = 0;
          if (i_wdata == word_sum()) m_pending = 1;
          else m_err = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      chk("wready", 32'(o_wready), 32'(m_active && !i_abort));
      chk("busy", 32'(o_busy), 32'(m_active || m_pending || m_done));
      chk("load_done", 32'(o_load_done), 32'(m_done));
      chk("weights_valid", 32'(o_weights_valid), 32'(m_wv));
      chk("checksum_err", 32'(o_checksum_err), 32'(m_err));
      chkw("Wr", SW'(o_Wr_flat), seg(0, UF));
      chkw("Ur", SW'(o_Ur_flat), seg(UF, UU));
      chkw("br", SW'(o_br_flat), seg(UF + UU, U));
      chkw("Wz", SW'(o_Wz_flat), seg(L, UF));
      chkw("Uz", SW'(o_Uz_flat), seg(L + UF, UU));
      chkw("bz", SW'(o_bz_flat), seg(L + UF + UU, U));
      chkw("Wh", SW'(o_Wh_flat), seg(2 * L, UF));
      chkw("Uh", SW'(o_Uh_flat), seg(2 * L + UF, UU));
      chkw("bh", SW'(o_bh_flat), seg(2 * L + UF + UU, U));
      chkw("fc_w", SW'(o_fc_weights_flat), seg(3 * L, U));
      chk("fc_bias", o_fc_bias, m_out[3 * L + U]);
      if (o_load_done) done_cnt++;
    end
  end

  task automatic start_load();
    @(negedge clk);
    i_load_start = 1; i_wvalid = 0; i_abort = 0;
    @(posedge clk);
    #1;
    i_load_start = 0;
    s_cyc = cyc;
    tx_sum = '0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int gap, input bit poke);
    int waited;
    repeat (gap) begin
      @(negedge clk);
      i_wvalid = 0; i_wdata = $urandom; i_load_start = 0;
    end
    @(negedge clk);
    i_wvalid = 1; i_wdata = d;
    i_load_start = poke && ($urandom_range(0, 5) == 0);
    #1;
    waited = 0;
    while (!o_wready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!o_wready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got ready=0 required ready=1 (t=%0t)", $time);
    end else begin
      tx_sum = tx_sum + d;
    end
    @(posedge clk);
  endtask

  task automatic send_tail(input logic [DW-1:0] extra);
    if (CK != 0) send_word(tx_sum + extra, 0, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      i_load_start = 0;
      #1;
      if (o_load_done) begin lat = cyc - s_cyc; break; end
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no o_load_done required a pulse (t=%0t)", $time);
    end
    i_wvalid = 0;
  endtask

  task automatic pins_first_set();
    chk("pin_Wr0", o_Wr_flat[DW-1:0], 1);
    chk("pin_Ur0", o_Ur_flat[DW-1:0], 10);
    chk("pin_br0", o_br_flat[DW-1:0], 19);
    chk("pin_Wz0", o_Wz_flat[DW-1:0], 22);
    chk("pin_Uz0", o_Uz_flat[DW-1:0], 31);
    chk("pin_bz0", o_bz_flat[DW-1:0], 40);
    chk("pin_Wh0", o_Wh_flat[DW-1:0], 43);
    chk("pin_Uh0", o_Uh_flat[DW-1:0], 52);
    chk("pin_bh0", o_bh_flat[DW-1:0], 61);
    chk("pin_fcw0", o_fc_weights_flat[DW-1:0], 64);
    chk("pin_fcb", o_fc_bias, 67);
  endtask

  initial begin
    int lat;
    int dc0;
    rst = 1; i_load_start = 0; i_abort = 0; i_wvalid = 0; i_wdata = '0; tx_sum = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_wready", 32'(o_wready), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_wv", 32'(o_weights_valid), 0);
    chkw("rst_Wr", SW'(o_Wr_flat), '0);
    chk("rst_fcb", o_fc_bias, 0);

    // Full load 1..N at one word per cycle, then extra words that must be refused.
    dc0 = done_cnt;
    start_load();
    for (int i = 1; i <= N; i++) send_word(DW'(i), 0, 0);
`ifdef GRU_WEIGHT_CHECKSUM_EN
    send_word(32'h8E6, 0, 0);
`endif
    @(negedge clk);
    i_wvalid = 1; i_wdata = 32'hDEAD_BEEF;
    wait_done(lat);
    chk("lat_full", lat, N + 1 + CK);
    repeat (3) @(negedge clk);
    #3;
    chk("done_once", done_cnt - dc0, 1);
    chk("wv_set", 32'(o_weights_valid), 1);
    pins_first_set();

    // Valid toggled every other cycle.
    dc0 = done_cnt;
    start_load();
    for (int i = 1; i <= N; i++) send_word(DW'(i), (i == 1) ? 0 : 1, 0);
    if (CK != 0) send_word(tx_sum, 1, 0);
    wait_done(lat);
    chk("lat_toggle", lat, 2 * N + 2 * CK);
    repeat (3) @(negedge clk);
    #3;
    chk("done_toggle", done_cnt - dc0, 1);
    pins_first_set();

    // Abort after 30 words of a second set.
    dc0 = done_cnt;
    start_load();
    for (int i = 0; i < 30; i++) send_word(DW'(100 + i), 0, 0);
    @(negedge clk);
    i_wvalid = 1; i_wdata = 32'd999; i_abort = 1;
    @(negedge clk);
    i_abort = 0; i_wvalid = 0;
    #1;
    chk("abort_busy", 32'(o_busy), 0);
    repeat (6) @(negedge clk);
    #3;
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_wv", 32'(o_weights_valid), 1);
    pins_first_set();

    // Random words, random gaps, stray start pulses mid-load.
    for (int it = 0; it < 3; it++) begin
      start_load();
      for (int i = 0; i < N; i++) send_word($urandom, $urandom_range(0, 2), 1);
      send_tail('0);
      wait_done(lat);
    end

    // Reset at word 40, then a fresh load.
    start_load();
    for (int i = 0; i < 40; i++) send_word($urandom, $urandom_range(0, 1), 0);
    @(negedge clk);
    rst = 1; i_wvalid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("mid_rst_wv", 32'(o_weights_valid), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    chkw("mid_rst_Wr", SW'(o_Wr_flat), '0);
    chk("mid_rst_fcb", o_fc_bias, 0);
    start_load();
    for (int i = 0; i < N; i++) send_word($urandom, $urandom_range(0, 1), 0);
    send_tail('0);
    wait_done(lat);
    chk("lat_after_rst_min", 32'(lat >= N + 1 + CK), 1);
    repeat (2) @(negedge clk);
    #3;
    chk("wv_after_rst", 32'(o_weights_valid), 1);

`ifdef GRU_WEIGHT_CHECKSUM_EN
    // Bad checksum: no commit, error flag sticky until the next start.
    dc0 = done_cnt;
    start_load();
    for (int i = 1; i <= N; i++) send_word(DW'(i), 0, 0);
    send_word(32'h8E7, 0, 0);
    repeat (4) @(negedge clk);
    #3;
    chk("ck_err", 32'(o_checksum_err), 1);
    chk("ck_no_done", done_cnt - dc0, 0);
    chk("ck_wv", 32'(o_weights_valid), 1);
    start_load();
    @(negedge clk);
    #3;
    chk("ck_err_cleared", 32'(o_checksum_err), 0);
    i_abort = 1;
    @(negedge clk);
    i_abort = 0;
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
